// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial converter. Accepts WIDTH-bit words through a
//   valid/ready handshake into a one-entry holding register. It then shifts
//   each word out one bit per clock, starting with either the MSB or the LSB.
//   A word that is already held is started in the cycle right after the
//   previous word's last bit, so consecutive words stream with no gap.
//
// Parameters
//   WIDTH      bits per parallel word (1..32)
//   MSB_FIRST  1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   din         parallel word to serialize
//   din_valid   din holds a word to transfer
//   din_ready   block can accept din this cycle (combinational)
//   dout        serial bit, registered, 0 when dout_valid=0
//   dout_valid  dout carries a data bit this cycle
//   word_done   pulse coincident with the last bit of each word
//   busy        a word is held or being shifted

module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [WIDTH-1:0] shift_reg, shift_next, shifted;
  logic [CW-1:0]    cnt, cnt_next;
  logic             dout_next, dout_valid_next, word_done_next;
  logic             xfer, accept;

  // The held word moves into the shifter when the shifter is empty, or when
  // the bit now on dout is the last bit of the current word.
  assign xfer      = hold_full && ((state == IDLE) || (cnt == LAST));
  assign din_ready = !reset && (!hold_full || xfer);
  assign accept    = din_valid && din_ready;
  assign busy      = dout_valid || hold_full;

  // Holding register. A new word may be captured on the same edge that the
  // old held word moves into the shifter, so an accept takes priority over
  // clearing the full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= din;
      hold_full <= 1'b1;
    end else if (xfer) begin
      hold_full <= 1'b0;
    end
  end

  // State, shifter, counter and the registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      cnt        <= cnt_next;
      dout       <= dout_next;
      dout_valid <= dout_valid_next;
      word_done  <= word_done_next;
    end
  end

  // Next-state logic. The shifter keeps the bit currently on dout at its
  // outgoing end, so the next bit is read from the shifted value.
  always_comb begin
    state_next      = state;
    shift_next      = shift_reg;
    cnt_next        = cnt;
    dout_next       = 1'b0;
    dout_valid_next = 1'b0;
    word_done_next  = 1'b0;
    shifted         = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

    if (xfer) begin
      state_next      = SHIFT;
      shift_next      = hold_reg;
      cnt_next        = '0;
      dout_next       = MSB_FIRST ? hold_reg[WIDTH-1] : hold_reg[0];
      dout_valid_next = 1'b1;
      word_done_next  = (WIDTH == 1);
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state_next = IDLE;
            shift_next = '0;
            cnt_next   = '0;
          end else begin
            shift_next      = shifted;
            cnt_next        = cnt + CW'(1);
            dout_next       = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
            dout_valid_next = 1'b1;
            word_done_next  = ((cnt + CW'(1)) == LAST);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Directed self-checking bench for bit_serializer. It uses three instances:
//   u0 is WIDTH=8 MSB first, u1 is WIDTH=8 LSB first, and u2 is WIDTH=1.
//   Inputs change 1 ns after each rising edge. Outputs are sampled 1 ns
//   later, once the combinational din_ready has settled.

module tb_bit_serializer;

  logic clk = 1'b0;
  logic reset;

  logic [7:0] d0;
  logic       v0, r0, o0, ov0, wd0, b0;
  logic [7:0] d1;
  logic       v1, r1, o1, ov1, wd1, b1;
  logic [0:0] d2;
  logic       v2, r2, o2, ov2, wd2, b2;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp16;
  logic [23:0] exp24;
  logic [7:0]  exp8;
  logic [7:0]  bp_words [3];
  int          k;
  int          bi;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .din(d0), .din_valid(v0), .din_ready(r0),
    .dout(o0), .dout_valid(ov0), .word_done(wd0), .busy(b0)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset(reset), .din(d1), .din_valid(v1), .din_ready(r1),
    .dout(o1), .dout_valid(ov1), .word_done(wd1), .busy(b1)
  );

  bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .reset(reset), .din(d2), .din_valid(v2), .din_ready(r2),
    .dout(o2), .dout_valid(ov2), .word_done(wd2), .busy(b2)
  );

  // Compare one observed bit against the hand-computed value.
  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive the u0 inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [7:0] d, input logic v);
    d0 = d;
    v0 = v;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    d0 = '0; v0 = 1'b0;
    d1 = '0; v1 = 1'b0;
    d2 = '0; v2 = 1'b0;
    bp_words[0] = 8'h81;
    bp_words[1] = 8'h5A;
    bp_words[2] = 8'hC3;

    // Reset state, with din_valid asserted during reset.
    stepCycle();
    applyStimulus(8'hAA, 1'b1);
    stepCycle();
    checkOutput("rst_ready0", r0, 1'b0);
    checkOutput("rst_dvalid0", ov0, 1'b0);
    checkOutput("rst_dout0", o0, 1'b0);
    checkOutput("rst_done0", wd0, 1'b0);
    checkOutput("rst_busy0", b0, 1'b0);
    checkOutput("rst_ready1", r1, 1'b0);
    checkOutput("rst_ready2", r2, 1'b0);
    reset = 1'b0;
    applyStimulus(8'h00, 1'b0);
    checkOutput("post_rst_ready0", r0, 1'b1);
    checkOutput("post_rst_busy0", b0, 1'b0);

    // A single word 8'hD0 gives latency 2, then 1,1,0,1,0,0,0,0.
    applyStimulus(8'hD0, 1'b1);
    checkOutput("d0_ready", r0, 1'b1);
    stepCycle();
    applyStimulus(8'h00, 1'b0);
    checkOutput("d0_t1_dvalid", ov0, 1'b0);
    checkOutput("d0_t1_busy", b0, 1'b1);
    stepCycle();
    exp8 = 8'hD0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("d0_valid_%0d", i), ov0, 1'b1);
      checkOutput($sformatf("d0_bit_%0d", i), o0, exp8[7-i]);
      checkOutput($sformatf("d0_done_%0d", i), wd0, (i == 7));
      stepCycle();
    end
    checkOutput("d0_end_dvalid", ov0, 1'b0);
    checkOutput("d0_end_dout", o0, 1'b0);
    checkOutput("d0_end_busy", b0, 1'b0);
    checkOutput("d0_end_done", wd0, 1'b0);

    // Back-to-back words 8'hA5 then 8'h3C with din_valid held high.
    applyStimulus(8'hA5, 1'b1);
    checkOutput("bb_ready_a", r0, 1'b1);
    stepCycle();
    applyStimulus(8'h3C, 1'b1);
    checkOutput("bb_ready_b", r0, 1'b1);
    stepCycle();
    applyStimulus(8'h00, 1'b0);
    exp16 = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("bb_valid_%0d", i), ov0, 1'b1);
      checkOutput($sformatf("bb_bit_%0d", i), o0, exp16[15-i]);
      checkOutput($sformatf("bb_done_%0d", i), wd0, (i == 7) || (i == 15));
      stepCycle();
    end
    checkOutput("bb_end_dvalid", ov0, 1'b0);

    // Backpressure test. Three words are offered continuously, and the third
    // is accepted in the cycle that carries the last bit of word 1.
    exp24 = {8'h81, 8'h5A, 8'hC3};
    k = 0;
    for (int cyc = 0; cyc <= 26; cyc++) begin
      if (k < 3) applyStimulus(bp_words[k], 1'b1);
      else       applyStimulus(8'h00, 1'b0);
      if (cyc <= 9)
        checkOutput($sformatf("bp_ready_c%0d", cyc), r0, (cyc <= 1) || (cyc == 9));
      if (cyc >= 2 && cyc <= 25) begin
        bi = cyc - 2;
        checkOutput($sformatf("bp_valid_%0d", bi), ov0, 1'b1);
        checkOutput($sformatf("bp_bit_%0d", bi), o0, exp24[23-bi]);
        checkOutput($sformatf("bp_done_%0d", bi), wd0, (bi % 8) == 7);
      end else begin
        checkOutput($sformatf("bp_idle_c%0d", cyc), ov0, 1'b0);
      end
      if (k < 3 && r0) k++;
      stepCycle();
    end
    checkOutput("bp_accept_count", (k == 3), 1'b1);
    checkOutput("bp_end_busy", b0, 1'b0);

    // Reset after 3 bits of 8'hFF while 8'h0F is held.
    applyStimulus(8'hFF, 1'b1);
    checkOutput("rs_ready_a", r0, 1'b1);
    stepCycle();
    applyStimulus(8'h0F, 1'b1);
    checkOutput("rs_ready_b", r0, 1'b1);
    stepCycle();
    applyStimulus(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rs_bit_%0d", i), o0, 1'b1);
      checkOutput($sformatf("rs_valid_%0d", i), ov0, 1'b1);
      stepCycle();
    end
    checkOutput("rs_busy_before", b0, 1'b1);
    reset = 1'b1;
    applyStimulus(8'h55, 1'b1);
    checkOutput("rs_ready_in_reset", r0, 1'b0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(8'h00, 1'b0);
    checkOutput("rs_dvalid_after", ov0, 1'b0);
    checkOutput("rs_busy_after", b0, 1'b0);
    checkOutput("rs_ready_after", r0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("rs_quiet_%0d", i), ov0, 1'b0);
      stepCycle();
    end

    // LSB-first case: 8'h0B gives 1,1,0,1,0,0,0,0.
    d1 = 8'h0B; v1 = 1'b1; #1;
    checkOutput("lsb_ready", r1, 1'b1);
    stepCycle();
    v1 = 1'b0; d1 = 8'h00; #1;
    stepCycle();
    exp8 = 8'h0B;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("lsb_valid_%0d", i), ov1, 1'b1);
      checkOutput($sformatf("lsb_bit_%0d", i), o1, exp8[i]);
      checkOutput($sformatf("lsb_done_%0d", i), wd1, (i == 7));
      stepCycle();
    end
    checkOutput("lsb_end_dvalid", ov1, 1'b0);

    // WIDTH=1 case: words 1,0,1 come out back-to-back with word_done on each.
    d2 = 1'b1; v2 = 1'b1; #1;
    checkOutput("w1_ready_0", r2, 1'b1);
    stepCycle();
    d2 = 1'b0; #1;
    checkOutput("w1_ready_1", r2, 1'b1);
    checkOutput("w1_t1_dvalid", ov2, 1'b0);
    stepCycle();
    d2 = 1'b1; #1;
    checkOutput("w1_ready_2", r2, 1'b1);
    checkOutput("w1_valid_0", ov2, 1'b1);
    checkOutput("w1_bit_0", o2, 1'b1);
    checkOutput("w1_done_0", wd2, 1'b1);
    stepCycle();
    v2 = 1'b0; d2 = 1'b0; #1;
    checkOutput("w1_valid_1", ov2, 1'b1);
    checkOutput("w1_bit_1", o2, 1'b0);
    checkOutput("w1_done_1", wd2, 1'b1);
    stepCycle();
    checkOutput("w1_valid_2", ov2, 1'b1);
    checkOutput("w1_bit_2", o2, 1'b1);
    checkOutput("w1_done_2", wd2, 1'b1);
    stepCycle();
    checkOutput("w1_end_dvalid", ov2, 1'b0);
    checkOutput("w1_end_done", wd2, 1'b0);
    checkOutput("w1_end_busy", b2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of bits per parallel word (legal range 1..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = din[WIDTH-1] shifted out first, 0 = din[0] first.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1  din holds a word to transfer.
REQ-007 SHALL have port din_ready  output  1  block can accept din this cycle.
REQ-008 SHALL have port dout  output  1  serial bit stream feeding the downstream sequence detector input.
REQ-009 SHALL have port dout_valid  output  1  dout carries a data bit this cycle.
REQ-010 SHALL have port word_done  output  1  one-cycle pulse coincident with the last bit of each word.
REQ-011 SHALL have port busy  output  1  a word is held or being shifted.

Function
REQ-012 SHALL contain a one-entry holding register (hold_full flag) and a WIDTH-bit shift register with bit counter (0..WIDTH-1).
REQ-013 SHALL implement state machine IDLE (shifter empty) and SHIFT (shifter presenting a bit every cycle).
REQ-014 SHALL transfer a word on a cycle with din_valid=1 and din_ready=1; din is captured into the holding register at that edge.
REQ-015 SHALL drive din_ready combinationally = !hold_full OR (hold transfers to shifter this cycle).
REQ-016 SHALL ignore din while din_valid=0 or din_ready=0; no capture, no state change.
REQ-017 SHALL move the holding word into the shifter at the edge ending a cycle where hold_full=1 and (state=IDLE or bit counter=WIDTH-1); state becomes/stays SHIFT, counter=0.
REQ-018 SHALL present the first bit of a word accepted in cycle T during cycle T+2 when the block was IDLE and hold empty (latency 2), and its WIDTH bits in consecutive cycles T+2..T+WIDTH+1.
REQ-019 SHALL emit back-to-back words with no idle cycle when the next word is held by the cycle carrying the current word's last bit.
REQ-020 SHALL return to IDLE after the last bit when hold_full=0; dout_valid=0 the following cycle.
REQ-021 SHALL assert word_done only in the cycle dout carries bit index WIDTH-1 of a word.
REQ-022 SHALL drive dout=0 whenever dout_valid=0.
REQ-023 SHALL drive busy = dout_valid OR hold_full.
REQ-024 SHALL, for WIDTH=1, present one bit per word with word_done=1 on every valid bit.
REQ-025 SHALL, on simultaneous hold-to-shifter transfer and new accept, load the shifter with the old held word and capture the new word into the holding register in the same edge.
REQ-026 SHALL register dout, dout_valid, and word_done (no combinational path from din to dout).

Reset
REQ-027 SHALL, while reset=1 at a rising edge, clear hold_full, shifter, counter, state=IDLE, dout=0, dout_valid=0, word_done=0, busy=0.
REQ-028 SHALL discard any partially shifted and any held word on reset; no remaining bits appear after reset releases.
REQ-029 SHALL drive din_ready=0 in any cycle where reset=1, and din_ready=1 in the first cycle after reset deasserts.
REQ-030 SHALL ignore din_valid in any cycle where reset=1.

Verification
REQ-031 SHALL verify WIDTH=8, MSB_FIRST=1, din=8'hD0 accepted cycle T -> dout 1,1,0,1,0,0,0,0 in T+2..T+9, word_done only at T+9, dout_valid=0 at T+10.
REQ-032 SHALL verify din_valid held high with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101 00111100, no gap, word_done at bits 8 and 16.
REQ-033 SHALL verify backpressure: three words offered continuously -> din_ready=0 while hold full and shifter mid-word, third word accepted in the cycle word 1's last bit shifts, no word lost or duplicated.
REQ-034 SHALL verify reset asserted after 3 bits of 8'hFF with 8'h0F held -> dout_valid=0 and busy=0 the next cycle; no bits of either word appear afterwards.
REQ-035 SHALL verify MSB_FIRST=0, din=8'h0B -> dout 1,1,0,1,0,0,0,0.
REQ-036 SHALL verify WIDTH=1, words 1,0,1 back-to-back -> dout 1,0,1 in consecutive cycles, word_done=1 on each.
